// File: rtl/interp_pkg.sv
// Shared FSM encoding and window geometry for the upsample-by-2 interpolator.
package interp_pkg;

  localparam int TAPS   = 7;
  localparam int CENTER = 3;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    WAIT   = 2'd1,
    ORIG   = 2'd2,
    INTERP = 2'd3
  } state_t;

endpackage

// File: rtl/interp_ctrl_if.sv
// Sample stream bus. Both directions use valid/ready: a beat moves on a rising
// edge where valid && ready; the source holds data and valid stable until then.
interface interp_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic signed [DATA_WIDTH+1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH+1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/filtroup.sv
// 7-tap symmetric smoothing FIR, taps (1,-2,9,16,9,-2,1)/32, floor-shifted and
// saturated back to the sample width.
module filtroup #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH+1:0] in0,
  input  logic signed [DATA_WIDTH+1:0] in1,
  input  logic signed [DATA_WIDTH+1:0] in2,
  input  logic signed [DATA_WIDTH+1:0] in3,
  input  logic signed [DATA_WIDTH+1:0] in4,
  input  logic signed [DATA_WIDTH+1:0] in5,
  input  logic signed [DATA_WIDTH+1:0] in6,
  output logic signed [DATA_WIDTH+1:0] result
);

  // Absolute tap sum is 40 < 2^6, so 7 guard bits cover the accumulator.
  localparam int SW = DATA_WIDTH + 9;
  localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_WIDTH-1){1'b0}}, {(DATA_WIDTH+1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DATA_WIDTH-1){1'b1}}, {(DATA_WIDTH+1){1'b0}}};

  logic signed [SW-1:0] w_x0, w_x1, w_x2, w_x3, w_x4, w_x5, w_x6;
  logic signed [SW-1:0] w_acc;
  logic signed [SW-1:0] w_shift;

  always_comb begin
    w_x0 = SW'(in0);
    w_x1 = SW'(in1);
    w_x2 = SW'(in2);
    w_x3 = SW'(in3);
    w_x4 = SW'(in4);
    w_x5 = SW'(in5);
    w_x6 = SW'(in6);
    w_acc = (w_x0 + w_x6)
          - ((w_x1 + w_x5) <<< 1)
          + ((w_x2 + w_x4) <<< 3) + (w_x2 + w_x4)
          + (w_x3 <<< 4);
    w_shift = w_acc >>> 5;
    if (w_shift > MAXV)      result = MAXV[DATA_WIDTH+1:0];
    else if (w_shift < MINV) result = MINV[DATA_WIDTH+1:0];
    else                     result = w_shift[DATA_WIDTH+1:0];
  end

endmodule

// File: rtl/interp_ctrl.sv
// Upsample-by-2 controller: each accepted sample emits the window centre and
// then the filtroup value for the same window.
module interp_ctrl
  import interp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  interp_ctrl_if.slave        bus,
  output logic [2:0]          fill_cnt,
  output state_t              o_dbg_state
);

  localparam int DW = $bits(bus.in_data);

  state_t                r_state, w_next;
  logic signed [DW-1:0]  r_win [TAPS];
  logic [2:0]            r_fill_cnt;
  logic signed [DW-1:0]  r_out_data;
  logic                  r_out_valid;
  logic                  w_in_ready, w_accept, w_xfer;
  logic signed [DW-1:0]  w_filt;

  filtroup #(.DATA_WIDTH(DW-2)) u_filt (
    .in0(r_win[0]), .in1(r_win[1]), .in2(r_win[2]), .in3(r_win[3]),
    .in4(r_win[4]), .in5(r_win[5]), .in6(r_win[6]),
    .result(w_filt)
  );

  always_comb begin
    w_next     = r_state;
    w_in_ready = (r_state == FILL) || (r_state == WAIT);
    w_accept   = bus.in_valid && w_in_ready;
    w_xfer     = r_out_valid && bus.out_ready;
    case (r_state)
      FILL:   if (w_accept && (r_fill_cnt == 3'(TAPS-1))) w_next = ORIG;
      WAIT:   if (w_accept) w_next = ORIG;
      ORIG:   if (w_xfer)   w_next = INTERP;
      INTERP: if (w_xfer)   w_next = WAIT;
      default:              w_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state     <= FILL;
      r_fill_cnt  <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < TAPS; k++) r_win[k] <= '0;
      if (!rst_n) r_out_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        for (int k = 1; k < TAPS; k++) r_win[k] <= r_win[k-1];
        r_win[0] <= bus.in_data;
        if (r_state == FILL) r_fill_cnt <= r_fill_cnt + 3'd1;
      end
      // The pre-shift entry CENTER-1 becomes w[CENTER] on this same edge.
      if (w_accept && (w_next == ORIG)) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_win[CENTER-1];
      end
      if ((r_state == ORIG) && w_xfer)   r_out_data  <= w_filt;
      if ((r_state == INTERP) && w_xfer) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign fill_cnt      = r_fill_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_interp_ctrl.sv
// Directed bench for interp_ctrl: warm-up, steady state, backpressure, flush
// and mid-run reset, with hand-computed filtroup values.
module tb_interp_ctrl;
  import interp_pkg::*;

  localparam int DW = 8;
  localparam int IW = DW + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  fill_cnt;
  state_t      dbg_state;
  int          n_tests = 0;
  int          n_fail  = 0;

  interp_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  interp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .fill_cnt(fill_cnt), .o_dbg_state(dbg_state)
  );

  // Standalone filtroup for the first interpolated value of the warm-up window.
  logic signed [IW-1:0] ref_in [7];
  logic signed [IW-1:0] ref_res;
  filtroup #(.DATA_WIDTH(DW)) u_ref (
    .in0(ref_in[0]), .in1(ref_in[1]), .in2(ref_in[2]), .in3(ref_in[3]),
    .in4(ref_in[4]), .in5(ref_in[5]), .in6(ref_in[6]), .result(ref_res)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic feed(input int v);
    bus.in_valid = 1'b1;
    bus.in_data  = IW'(v);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int seq1 [7];
    seq1 = '{16, 30, 251, 54, 17, 142, 232};
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = IW'(77); bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) ref_in[k] = IW'(seq1[6-k]);

    // Reset with a valid input present
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fill_cnt", 32'(fill_cnt), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(FILL));
    rst_n = 1'b1;

    // Warm-up: first six samples give no output
    for (int i = 0; i < 6; i++) begin
      feed(seq1[i]);
      chk("warm_no_valid", 32'(bus.out_valid), 32'd0);
      chk("warm_fill_cnt", 32'(fill_cnt), 32'(i + 1));
    end
    feed(seq1[6]);
    chk("w7_out_valid", 32'(bus.out_valid), 32'd1);
    chk("w7_out_data", 32'(bus.out_data), 32'd54);
    chk("w7_fill_cnt", 32'(fill_cnt), 32'd7);
    chk("w7_in_ready", 32'(bus.in_ready), 32'd0);
    chk("ref_filt", 32'(ref_res), 32'd99);
    tick();
    chk("w7_interp_data", 32'(bus.out_data), 32'd99);
    chk("w7_interp_vs_ref", 32'(bus.out_data), 32'(ref_res));
    chk("w7_interp_valid", 32'(bus.out_valid), 32'd1);
    chk("w7_interp_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("w7_done_valid", 32'(bus.out_valid), 32'd0);
    chk("w7_done_ready", 32'(bus.in_ready), 32'd1);
    chk("w7_done_state", 32'(dbg_state), 32'(WAIT));

    // Steady state: sample 5, window 5,232,142,17,54,251,30
    feed(5);
    chk("s5_orig_data", 32'(bus.out_data), 32'd17);
    chk("s5_orig_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("s5_interp_data", 32'(bus.out_data), 32'd34);
    chk("s5_interp_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("s5_wait_ready", 32'(bus.in_ready), 32'd1);
    chk("s5_wait_valid", 32'(bus.out_valid), 32'd0);
    chk("s5_fill_cnt", 32'(fill_cnt), 32'd7);

    // Backpressure in ORIG: window 9,5,232,142,17,54,251
    bus.out_ready = 1'b0;
    feed(9);
    chk("bp_orig_data", 32'(bus.out_data), 32'd142);
    bus.in_valid = 1'b1; bus.in_data = IW'(100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", 32'(bus.out_data), 32'd142);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_state", 32'(dbg_state), 32'(ORIG));
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("bp_interp_data", 32'(bus.out_data), 32'd145);
    chk("bp_interp_state", 32'(dbg_state), 32'(INTERP));

    // Flush in INTERP with a same-cycle input
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = IW'(200);
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_fill_cnt", 32'(fill_cnt), 32'd0);
    chk("fl_state", 32'(dbg_state), 32'(FILL));
    tick();
    chk("fl_not_accepted", 32'(fill_cnt), 32'd0);

    // Refill with 1..7, window 7,6,5,4,3,2,1
    for (int i = 1; i <= 7; i++) feed(i);
    chk("rf_orig_data", 32'(bus.out_data), 32'd4);
    chk("rf_orig_valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("rf_interp_data", 32'(bus.out_data), 32'd4);
    tick();
    chk("rf_wait_state", 32'(dbg_state), 32'(WAIT));
    chk("rf_wait_fill", 32'(fill_cnt), 32'd7);

    // One-cycle reset in WAIT; seven new samples needed
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.in_data = IW'(50);
    tick();
    rst_n = 1'b1; bus.in_valid = 1'b0;
    chk("mr_fill_cnt", 32'(fill_cnt), 32'd0);
    chk("mr_state", 32'(dbg_state), 32'(FILL));
    chk("mr_out_data", 32'(bus.out_data), 32'd0);
    for (int i = 0; i < 6; i++) begin
      feed(-3 * i);
      chk("mr_no_valid", 32'(bus.out_valid), 32'd0);
    end
    feed(11);
    chk("mr_valid_after7", 32'(bus.out_valid), 32'd1);
    // Window 11,-15,-12,-9,-6,-3,0: centre is -9
    chk("mr_neg_center", 32'(bus.out_data), 32'(-9));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interp_ctrl.md
INTERP_CTRL -- requirements
Module: interp_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: sample magnitude width; every data port is DATA_WIDTH+2 bits signed.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port flush  input  1  synchronous clear of the sample window and the fill count.
REQ-005 SHALL have port in_data  input  DATA_WIDTH+2  signed input sample.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port out_data  output  DATA_WIDTH+2  signed output sample, registered.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port fill_cnt  output  3  number of valid window entries, 0..7.

Function
REQ-012 SHALL treat a sample as accepted when in_valid && in_ready, and an output as transferred when out_valid && out_ready.
REQ-013 SHALL hold a 7-entry window w[0..6]; on acceptance w[k] <= w[k-1] for k=1..6 and w[0] <= in_data.
REQ-014 SHALL drive the filtroup instance with in0..in6 = w[0]..w[6], using its DATA_WIDTH+2-bit result without resizing.
REQ-015 SHALL implement the FSM states FILL, WAIT, ORIG and INTERP.
REQ-016 SHALL assert in_ready = 1 only in FILL and WAIT.
REQ-017 SHALL, in FILL, increment fill_cnt on each acceptance; on the acceptance that makes fill_cnt 7, go to ORIG.
REQ-018 SHALL, in WAIT, go to ORIG on acceptance; fill_cnt stays at 7.
REQ-019 SHALL, on entry to ORIG, set out_valid = 1 and out_data = w[3] after the shift, so the accepting edge to out_valid is 1 cycle.
REQ-020 SHALL, in ORIG on transfer, load out_data with the filtroup result for the current window, keep out_valid = 1 and go to INTERP.
REQ-021 SHALL, in INTERP on transfer, clear out_valid and go to WAIT.
REQ-022 SHALL, while out_valid && !out_ready, hold out_data, out_valid and the window unchanged, because in_ready is 0 in ORIG and INTERP.
REQ-023 SHALL produce exactly 2 output samples per accepted sample after warm-up, giving upsample-by-2.
REQ-024 SHALL give flush priority over every event: w <= 0, fill_cnt <= 0, out_valid <= 0, state <= FILL, and discard any pending output and any same-cycle input.
REQ-025 SHALL sustain at best 1 input per 3 cycles: accept, ORIG, INTERP.

Reset
REQ-026 SHALL, when rst_n = 0 at a clock edge, set state FILL, w[0..6] = 0, fill_cnt = 0, out_valid = 0 and out_data = 0, regardless of other inputs.
REQ-027 SHALL, for a reset mid-operation, drop the pending output and resume warm-up from 0 samples.

Structure
REQ-028 SHALL place the FSM state encoding and the constants TAPS = 7 and CENTER = 3 in a shared package, interp_pkg.
REQ-029 SHALL contain exactly one sub-module, the existing filtroup, instantiated combinationally on the window.

Verification
REQ-030 SHALL cover: reset asserted with in_valid = 1 -> in_ready = 1, out_valid = 0, fill_cnt = 0; the next cycle accepts normally.
REQ-031 SHALL cover: feed 16,30,251,54,17,142,232 with out_ready = 1 -> no out_valid after 6 samples; 1 cycle after the 7th, out_data = 54; then the filtroup result for in0..in6 = 232,142,17,54,251,30,16, checked against a standalone filtroup.
REQ-032 SHALL cover: after warm-up, feed sample 5 -> out_data = 17 (the new w[3]) then the filtroup result of the shifted window; in_ready = 0 for exactly 2 cycles.
REQ-033 SHALL cover: out_ready held low 5 cycles in ORIG -> out_data is stable, in_ready = 0 and no sample is accepted.
REQ-034 SHALL cover: flush = 1 in INTERP together with in_valid = 1 -> next cycle out_valid = 0, fill_cnt = 0, state FILL, and the input is not accepted.
REQ-035 SHALL cover: rst_n low for 1 cycle during WAIT with fill_cnt = 7 -> fill_cnt = 0, and 7 new samples are needed before the next out_valid.
